// File: rtl/tart_dram_pkg.sv
// Shared types and defaults for the TART DRAM scheduler: FSM state encoding,
// default geometry and the circular-buffer depth helper.
package tart_dram_pkg;

    localparam int DEF_WIDTH  = 24;
    localparam int DEF_ABITS  = 21;
    localparam int DEF_STARVE = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } sched_state_e;

    // Number of sample slots in the circular buffer for a given address width.
    function automatic longint unsigned buf_depth(input int abits);
        return 64'd1 << abits;
    endfunction

endpackage

// File: rtl/tart_dram_scheduler_if.sv
// Single-port DRAM request bus shared by the capture writer and read prefetcher.
interface tart_dram_scheduler_if #(
    parameter int WIDTH = 24,
    parameter int ABITS = 21
);
    logic             req;
    logic             we;
    logic [ABITS-1:0] adr;
    logic [WIDTH-1:0] wdat;
    logic             ack;
    logic [WIDTH-1:0] rdat;

    modport master (output req, output we, output adr, output wdat,
                    input  ack, input  rdat);
    modport slave  (input  req, input  we, input  adr, input  wdat,
                    output ack, output rdat);
endinterface

// File: rtl/tart_dram_scheduler.sv
// Arbitrates one DRAM port between real-time sample capture (writes) and the
// SPI prefetcher (reads), managing DRAM as a circular buffer with a read-starvation limit.
module tart_dram_scheduler
    import tart_dram_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ABITS  = DEF_ABITS,
    parameter int STARVE = DEF_STARVE
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic                  wr_req_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    output logic                  wr_ack_o,
    input  logic                  rd_req_i,
    output logic                  rd_ready_o,
    output logic [WIDTH-1:0]      rd_data_o,
    tart_dram_scheduler_if.master mem,
    output logic [ABITS:0]        count_o,
    output logic                  overflow_o
);

    localparam int SBITS = $clog2(STARVE + 1);
    localparam logic [ABITS:0] FULL_CNT   = (ABITS+1)'(buf_depth(ABITS));
    localparam logic [SBITS-1:0] STARVE_S = SBITS'(STARVE);

    sched_state_e     state_r, state_n_s;
    logic [ABITS-1:0] wr_ptr_r, rd_ptr_r;
    logic [ABITS:0]   count_r;
    logic [SBITS-1:0] streak_r, streak_inc_s;
    logic             overflow_r;
    logic             wr_ack_r, rd_ready_r;
    logic [WIDTH-1:0] rd_data_r;
    logic             mem_req_r, mem_we_r;
    logic [ABITS-1:0] mem_adr_r;
    logic [WIDTH-1:0] mem_dat_r;

    logic wr_elig_s, rd_elig_s, full_s, pulse_busy_s, streak_max_s;
    logic clear_s, drop_s, grant_wr_s, grant_rd_s, done_wr_s, done_rd_s;

    assign wr_elig_s    = enable_i & wr_req_i;
    assign rd_elig_s    = rd_req_i & (count_r != {(ABITS+1){1'b0}});
    assign full_s       = (count_r == FULL_CNT);
    // Requesters still hold their level during the ack pulse, so IDLE must not re-sample then.
    assign pulse_busy_s = wr_ack_r | rd_ready_r;
    assign streak_max_s = (streak_r == STARVE_S);
    assign streak_inc_s = streak_max_s ? streak_r : streak_r + SBITS'(1);

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Next-state and per-cycle action decode; IDLE decisions are priority ordered.
    always_comb begin
        state_n_s  = state_r;
        clear_s    = 1'b0;
        drop_s     = 1'b0;
        grant_wr_s = 1'b0;
        grant_rd_s = 1'b0;
        done_wr_s  = 1'b0;
        done_rd_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!enable_i) begin
                    clear_s = 1'b1;
                end else if (pulse_busy_s) begin
                    state_n_s = ST_IDLE;
                end else if (wr_elig_s && full_s && !rd_elig_s) begin
                    drop_s = 1'b1;
                end else if (rd_elig_s && (streak_max_s || !wr_elig_s || full_s)) begin
                    grant_rd_s = 1'b1;
                    state_n_s  = ST_READ;
                end else if (wr_elig_s) begin
                    grant_wr_s = 1'b1;
                    state_n_s  = ST_WRITE;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (mem.ack) begin
                    done_wr_s = 1'b1;
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_WRITE;
                end
            end
            ST_READ: begin
                if (mem.ack) begin
                    done_rd_s = 1'b1;
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_READ;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // DRAM bus registers: captured at grant, held stable until ack.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_req_r <= 1'b0;
            mem_we_r  <= 1'b0;
            mem_adr_r <= {ABITS{1'b0}};
            mem_dat_r <= {WIDTH{1'b0}};
        end else if (grant_wr_s) begin
            mem_req_r <= 1'b1;
            mem_we_r  <= 1'b1;
            mem_adr_r <= wr_ptr_r;
            mem_dat_r <= wr_data_i;
        end else if (grant_rd_s) begin
            mem_req_r <= 1'b1;
            mem_we_r  <= 1'b0;
            mem_adr_r <= rd_ptr_r;
        end else if (done_wr_s || done_rd_s) begin
            mem_req_r <= 1'b0;
        end
    end

    // Buffer pointers, occupancy and overflow flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r   <= {ABITS{1'b0}};
            rd_ptr_r   <= {ABITS{1'b0}};
            count_r    <= {(ABITS+1){1'b0}};
            overflow_r <= 1'b0;
        end else if (clear_s) begin
            wr_ptr_r   <= {ABITS{1'b0}};
            rd_ptr_r   <= {ABITS{1'b0}};
            count_r    <= {(ABITS+1){1'b0}};
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (done_wr_s) begin
            wr_ptr_r <= wr_ptr_r + ABITS'(1);
            count_r  <= count_r + (ABITS+1)'(1);
        end else if (done_rd_s) begin
            rd_ptr_r <= rd_ptr_r + ABITS'(1);
            count_r  <= count_r - (ABITS+1)'(1);
        end
    end

    // Write streak: grows only while a read was being held off at write grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            streak_r <= {SBITS{1'b0}};
        end else if (clear_s || done_rd_s) begin
            streak_r <= {SBITS{1'b0}};
        end else if (grant_wr_s) begin
            streak_r <= rd_elig_s ? streak_inc_s : {SBITS{1'b0}};
        end
    end

    // Requester-side handshake pulses and read data holding register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ack_r   <= 1'b0;
            rd_ready_r <= 1'b0;
            rd_data_r  <= {WIDTH{1'b0}};
        end else begin
            wr_ack_r   <= drop_s | done_wr_s;
            rd_ready_r <= done_rd_s;
            if (done_rd_s) begin
                rd_data_r <= mem.rdat;
            end
        end
    end

    assign mem.req    = mem_req_r;
    assign mem.we     = mem_we_r;
    assign mem.adr    = mem_adr_r;
    assign mem.wdat   = mem_dat_r;
    assign wr_ack_o   = wr_ack_r;
    assign rd_ready_o = rd_ready_r;
    assign rd_data_o  = rd_data_r;
    assign count_o    = count_r;
    assign overflow_o = overflow_r;

endmodule

// File: tb/tb_tart_dram_scheduler.sv
// Scoreboard bench for tart_dram_scheduler: directed stimulus pushes expected grants
// and responses; a negedge monitor pops and compares them as the DUT produces them.
module tb_tart_dram_scheduler;

    localparam int W = 24;
    localparam int A = 3;

    typedef struct {
        bit          we;
        int          adr;
        logic [23:0] dat;
        int          cnt;
    } exp_t;

    exp_t grant_q[$];
    exp_t resp_q[$];

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          wr_req = 1'b0;
    logic [W-1:0]  wr_data = '0;
    logic          wr_ack;
    logic          rd_req = 1'b0;
    logic          rd_ready;
    logic [W-1:0]  rd_data;
    logic [A:0]    count;
    logic          overflow;

    int n_cmp = 0;
    int n_bad = 0;
    int ack_delay = 0;
    int wcnt = 0;
    logic req_q = 1'b0;
    logic [W-1:0] mem_arr [8];

    tart_dram_scheduler_if #(.WIDTH(W), .ABITS(A)) mem_bus ();

    tart_dram_scheduler #(.WIDTH(W), .ABITS(A), .STARVE(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable),
        .wr_req_i(wr_req), .wr_data_i(wr_data), .wr_ack_o(wr_ack),
        .rd_req_i(rd_req), .rd_ready_o(rd_ready), .rd_data_o(rd_data),
        .mem(mem_bus), .count_o(count), .overflow_o(overflow)
    );

    always #5 clk = ~clk;

    assign mem_bus.rdat = mem_arr[mem_bus.adr];

    // DRAM model: acks after ack_delay extra cycles, stores write data on ack.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_bus.ack <= 1'b0;
            wcnt        <= 0;
        end else if (mem_bus.req && !mem_bus.ack) begin
            if (wcnt >= ack_delay) begin
                mem_bus.ack <= 1'b1;
                wcnt        <= 0;
                if (mem_bus.we) mem_arr[mem_bus.adr] <= mem_bus.wdat;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            mem_bus.ack <= 1'b0;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops expected grants on mem request rise and responses on ack pulses.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (mem_bus.req && !req_q) begin
                if (grant_q.size() == 0) begin
                    check("unexpected_grant", {31'd0, mem_bus.we}, 32'hFFFF_FFFF);
                end else begin
                    e = grant_q.pop_front();
                    check("grant_we", {31'd0, mem_bus.we}, {31'd0, e.we});
                    check("grant_adr", {29'd0, mem_bus.adr}, e.adr);
                    if (e.we) check("grant_wdat", {8'd0, mem_bus.wdat}, {8'd0, e.dat});
                end
            end
            if (wr_ack && rd_ready) check("ack_overlap", 32'd1, 32'd0);
            if (wr_ack || rd_ready) begin
                if (resp_q.size() == 0) begin
                    check("unexpected_resp", {31'd0, wr_ack}, 32'hFFFF_FFFF);
                end else begin
                    e = resp_q.pop_front();
                    check("resp_kind_wr", {31'd0, wr_ack}, {31'd0, e.we});
                    check("resp_count", {28'd0, count}, e.cnt);
                    if (!e.we) check("rd_data", {8'd0, rd_data}, {8'd0, e.dat});
                end
            end
        end
        req_q <= mem_bus.req;
    end

    task automatic push(input bit we, input int adr, input logic [23:0] dat, input int cnt, input bit grant);
        exp_t e;
        e.we = we; e.adr = adr; e.dat = dat; e.cnt = cnt;
        if (grant) grant_q.push_back(e);
        resp_q.push_back(e);
    endtask

    task automatic wait_pulse(input bit want_wr, input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (want_wr ? wr_ack : rd_ready) seen = 1'b1;
        end
        if (!seen) check({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_write(input logic [23:0] d, input int a, input int c, input bit drop);
        push(1'b1, a, d, c, !drop);
        wr_data = d;
        wr_req  = 1'b1;
        wait_pulse(1'b1, "wr_ack");
        wr_req  = 1'b0;
    endtask

    task automatic do_read(input int a, input logic [23:0] d, input int c);
        push(1'b0, a, d, c, 1'b1);
        rd_req = 1'b1;
        wait_pulse(1'b0, "rd_ready");
        rd_req = 1'b0;
    endtask

    task automatic clear_buf();
        @(negedge clk); enable = 1'b0;
        @(negedge clk); @(negedge clk); enable = 1'b1;
    endtask

    initial begin
        int pulses, widx;
        logic [23:0] wd [8];
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req", {31'd0, mem_bus.req}, 32'd0);
        check("rst_count", {28'd0, count}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_acks", {30'd0, wr_ack, rd_ready}, 32'd0);
        rst_n = 1'b1;
        // Asynchronous reset in the middle of a stalled write
        enable = 1'b1; ack_delay = 10;
        grant_q.push_back('{1'b1, 0, 24'h5A5A5A, 0});
        wr_data = 24'h5A5A5A; wr_req = 1'b1;
        for (int i = 0; i < 20 && !mem_bus.req; i++) @(negedge clk);
        check("midwr_req", {31'd0, mem_bus.req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_req", {31'd0, mem_bus.req}, 32'd0);
        check("async_we", {31'd0, mem_bus.we}, 32'd0);
        check("async_data", {8'd0, rd_data}, 32'd0);
        wr_req = 1'b0; ack_delay = 0;
        @(negedge clk); rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_count", {28'd0, count}, 32'd0);
        check("post_rst_req", {31'd0, mem_bus.req}, 32'd0);

        // Write then read
        do_write(24'hABCDEF, 0, 1, 1'b0);
        do_write(24'h123456, 1, 2, 1'b0);
        do_read(0, 24'hABCDEF, 1);
        do_read(1, 24'h123456, 0);

        // Starvation limit: 4 writes, 1 read while both requests are held
        clear_buf();
        do_write(24'h0000A0, 0, 1, 1'b0);
        for (int k = 0; k < 8; k++) wd[k] = 24'h0000B0 + 24'(k);
        push(1, 1, wd[0], 2, 1); push(1, 2, wd[1], 3, 1);
        push(1, 3, wd[2], 4, 1); push(1, 4, wd[3], 5, 1);
        push(0, 0, 24'h0000A0, 4, 1);
        push(1, 5, wd[4], 5, 1); push(1, 6, wd[5], 6, 1);
        push(1, 7, wd[6], 7, 1); push(1, 0, wd[7], 8, 1);
        push(0, 1, wd[0], 7, 1);
        pulses = 0; widx = 0;
        wr_data = wd[0]; wr_req = 1'b1; rd_req = 1'b1;
        for (int i = 0; i < 400 && pulses < 10; i++) begin
            @(negedge clk);
            if (wr_ack || rd_ready) pulses++;
            if (wr_ack && widx < 7) begin widx++; wr_data = wd[widx]; end
        end
        wr_req = 1'b0; rd_req = 1'b0;
        check("starve_pulses", pulses, 32'd10);

        // Full buffer and overflow
        clear_buf();
        for (int i = 0; i < 8; i++) do_write(24'hF00 + 24'(i), i, i + 1, 1'b0);
        do_write(24'hBAD, 0, 8, 1'b1);
        check("ovf_set", {31'd0, overflow}, 32'd1);
        check("full_count", {28'd0, count}, 32'd8);
        push(0, 0, 24'hF00, 7, 1);
        push(1, 0, 24'h999, 8, 1);
        wr_data = 24'h999; wr_req = 1'b1; rd_req = 1'b1;
        for (int i = 0; i < 200 && (wr_req || rd_req); i++) begin
            @(negedge clk);
            if (rd_ready) rd_req = 1'b0;
            if (wr_ack) wr_req = 1'b0;
        end
        check("full_both_done", {30'd0, wr_req, rd_req}, 32'd0);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        clear_buf();
        check("clr_ovf", {31'd0, overflow}, 32'd0);
        check("clr_count", {28'd0, count}, 32'd0);

        // Pointer wrap
        for (int i = 0; i < 20; i++) begin
            do_write(24'h500 + 24'(i), i % 8, 1, 1'b0);
            do_read(i % 8, 24'h500 + 24'(i), 0);
        end

        // Disable while a slow read is outstanding
        clear_buf();
        do_write(24'h777, 0, 1, 1'b0);
        do_write(24'h778, 1, 2, 1'b0);
        ack_delay = 5;
        push(0, 0, 24'h777, 1, 1);
        rd_req = 1'b1;
        for (int i = 0; i < 20 && !mem_bus.req; i++) @(negedge clk);
        enable = 1'b0;
        wait_pulse(1'b0, "dis_rd_ready");
        rd_req = 1'b0;
        @(negedge clk);
        check("dis_count_clr", {28'd0, count}, 32'd0);
        ack_delay = 0; enable = 1'b1;
        do_write(24'h779, 0, 1, 1'b0);

        repeat (4) @(negedge clk);
        check("grant_q_empty", grant_q.size(), 32'd0);
        check("resp_q_empty", resp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
